// File: rtl/uart384_pkg.sv
// rtl/uart384_pkg.sv - shared command codes and tx FSM state encoding
package uart384_pkg;

    localparam logic [7:0] CMD_RESET  = 8'h72;
    localparam logic [7:0] CMD_STOP   = 8'h73;
    localparam logic [7:0] CMD_GO     = 8'h67;
    localparam logic [7:0] CMD_STATUS = 8'h3F;

    typedef logic [1:0] tx_state_t;

    localparam tx_state_t ST_IDLE      = 2'd0;
    localparam tx_state_t ST_WAIT_BUSY = 2'd1;
    localparam tx_state_t ST_WAIT_DONE = 2'd2;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - small synchronous byte FIFO with flush and registered head
module byte_fifo #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  logic [7:0] din,
    output logic       full,
    output logic       empty,
    output logic [7:0] head
);

    localparam int DEPTH = 1 << AW;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so a full FIFO still accepts a concurrent push.
    always_comb begin
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
    end

    // Pointer and occupancy bookkeeping; flush empties the FIFO and discards any concurrent push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; contents need no reset because head is only used when non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/entropy_tx_scheduler.sv
// rtl/entropy_tx_scheduler.sv - shares the uart transmitter between entropy bytes and host replies
module entropy_tx_scheduler
    import uart384_pkg::*;
#(
    parameter int FIFO_AW         = 2,
    parameter bit STREAM_AT_RESET = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       word_ready,
    input  logic [7:0] ent_byte,
    input  logic       rx_received,
    input  logic [7:0] rx_byte,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_byte,
    output logic       soft_reset_req,
    output logic       streaming,
    output logic [7:0] drop_count
);

    tx_state_t  state;
    logic [1:0] busy_wait;
    logic       reply_pending;
    logic [7:0] reply_byte;

    logic       cmd_reset;
    logic       cmd_stop;
    logic       cmd_go;
    logic       cmd_status;
    logic       can_launch;
    logic       take_reply;
    logic       take_entropy;
    logic       fifo_push;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       drop;

    // Command decode and launch decisions; a soft reset blocks any new launch in its cycle.
    always_comb begin
        cmd_reset    = rx_received && (rx_byte == CMD_RESET);
        cmd_stop     = rx_received && (rx_byte == CMD_STOP);
        cmd_go       = rx_received && (rx_byte == CMD_GO);
        cmd_status   = rx_received && (rx_byte == CMD_STATUS);
        can_launch   = (state == ST_IDLE) && !tx_busy && !cmd_reset;
        take_reply   = can_launch && reply_pending;
        take_entropy = can_launch && !reply_pending && streaming && !fifo_empty;
        fifo_push    = word_ready && streaming && !cmd_reset;
        drop         = fifo_push && fifo_full && !take_entropy;
    end

    byte_fifo #(
        .AW(FIFO_AW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (take_entropy),
        .flush (cmd_reset),
        .din   (ent_byte),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    // Host command effects: soft reset strobe, streaming gate and the pending status reply.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            soft_reset_req <= 1'b0;
            streaming      <= STREAM_AT_RESET;
            reply_pending  <= 1'b0;
            reply_byte     <= 8'h00;
        end else if (cmd_reset) begin
            soft_reset_req <= 1'b1;
            streaming      <= STREAM_AT_RESET;
            reply_pending  <= 1'b0;
        end else begin
            soft_reset_req <= 1'b0;
            if (cmd_stop) streaming <= 1'b0;
            if (cmd_go)   streaming <= 1'b1;
            if (take_reply) reply_pending <= 1'b0;
            if (cmd_status) begin
                reply_pending <= 1'b1;
                reply_byte    <= {streaming, drop_count[7:1]};
            end
        end
    end

    // Saturating count of entropy bytes lost to a full FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= 8'h00;
        end else if (cmd_reset) begin
            drop_count <= 8'h00;
        end else if (drop && (drop_count != 8'hFF)) begin
            drop_count <= drop_count + 8'h01;
        end
    end

    // Transmit sequencer: launch one byte, wait for the uart to go busy, then wait for it to finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy_wait <= 2'd0;
            tx_start  <= 1'b0;
            tx_byte   <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy_wait <= 2'd0;
                    if (take_reply) begin
                        tx_byte  <= reply_byte;
                        tx_start <= 1'b1;
                        state    <= ST_WAIT_BUSY;
                    end else if (take_entropy) begin
                        tx_byte  <= fifo_head;
                        tx_start <= 1'b1;
                        state    <= ST_WAIT_BUSY;
                    end
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (busy_wait == 2'd3) begin
                        state <= ST_IDLE;
                    end else begin
                        busy_wait <= busy_wait + 2'd1;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!tx_busy) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_entropy_tx_scheduler.sv
// tb/tb_entropy_tx_scheduler.sv - scoreboard bench for entropy_tx_scheduler
module tb_entropy_tx_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       word_ready;
    logic [7:0] ent_byte;
    logic       rx_received;
    logic [7:0] rx_byte;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_byte;
    logic       soft_reset_req;
    logic       streaming;
    logic [7:0] drop_count;

    int         checks = 0;
    int         passes = 0;
    logic [7:0] exp_q[$];
    logic       hold_busy = 1'b0;
    int         busy_left = 0;
    logic       prev_start = 1'b0;

    entropy_tx_scheduler #(
        .FIFO_AW         (2),
        .STREAM_AT_RESET (1'b1)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .word_ready     (word_ready),
        .ent_byte       (ent_byte),
        .rx_received    (rx_received),
        .rx_byte        (rx_byte),
        .tx_busy        (tx_busy),
        .tx_start       (tx_start),
        .tx_byte        (tx_byte),
        .soft_reset_req (soft_reset_req),
        .streaming      (streaming),
        .drop_count     (drop_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_word(input logic [7:0] b);
        word_ready = 1'b1;
        ent_byte   = b;
        cyc(1);
        word_ready = 1'b0;
    endtask

    task automatic rx_cmd(input logic [7:0] b);
        rx_received = 1'b1;
        rx_byte     = b;
        cyc(1);
        rx_received = 1'b0;
    endtask

    // uart model: goes busy on the negedge after tx_start and stays busy for 10 cycles
    initial begin
        forever begin
            @(negedge clk);
            if (tx_start) busy_left = 10;
            else if (busy_left > 0) busy_left--;
            tx_busy = hold_busy || (busy_left > 0);
        end
    end

    // monitor: every tx_start must carry the next expected byte
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_start) begin
                check("tx_start_gap", {31'd0, prev_start}, 32'd0);
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_tx_start: got tx_byte %0h expected no transmission", tx_byte);
                end else begin
                    check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
                end
            end
            prev_start = rst_n && tx_start;
        end
    end

    initial begin
        rst_n = 1'b1; word_ready = 1'b0; ent_byte = 8'h00;
        rx_received = 1'b0; rx_byte = 8'h00;
        #3 rst_n = 1'b0;
        cyc(3);
        check("rst_tx_start",   {31'd0, tx_start},       32'd0);
        check("rst_tx_byte",    {24'd0, tx_byte},        32'd0);
        check("rst_soft_reset", {31'd0, soft_reset_req}, 32'd0);
        check("rst_streaming",  {31'd0, streaming},      32'd1);
        check("rst_drop_count", {24'd0, drop_count},     32'd0);
        rst_n = 1'b1;
        cyc(2);

        // 1: single entropy byte
        exp_q.push_back(8'hA5);
        strobe_word(8'hA5);
        cyc(20);
        check("t1_drained", exp_q.size(), 0);

        // 2: uart blocked, overflow the FIFO, then release
        hold_busy = 1'b1;
        cyc(1);
        for (int i = 1; i <= 6; i++) strobe_word(8'(i));
        cyc(1);
        check("t2_drop_count", {24'd0, drop_count}, 32'd2);
        for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
        hold_busy = 1'b0;
        cyc(80);
        check("t2_drained", exp_q.size(), 0);

        // 3: stop keeps queued bytes and ignores new ones; go resumes
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(2);
        hold_busy = 1'b1;
        cyc(1);
        strobe_word(8'hC1);
        strobe_word(8'hC2);
        rx_cmd(8'h73);
        check("t3_streaming_off", {31'd0, streaming}, 32'd0);
        for (int i = 0; i < 3; i++) strobe_word(8'hD0 + 8'(i));
        hold_busy = 1'b0;
        cyc(20);
        check("t3_drop_count", {24'd0, drop_count}, 32'd0);
        exp_q.push_back(8'hC1);
        exp_q.push_back(8'hC2);
        rx_cmd(8'h67);
        check("t3_streaming_on", {31'd0, streaming}, 32'd1);
        cyc(40);
        check("t3_drained", exp_q.size(), 0);

        // 4: build drop_count=6, queue 2 bytes, status reply jumps ahead
        hold_busy = 1'b1;
        cyc(1);
        for (int i = 0; i < 10; i++) strobe_word(8'h10 + 8'(i));
        cyc(1);
        check("t4_drop_count", {24'd0, drop_count}, 32'd6);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h10 + 8'(i));
        hold_busy = 1'b0;
        cyc(80);
        check("t4_pre_drained", exp_q.size(), 0);
        hold_busy = 1'b1;
        cyc(1);
        strobe_word(8'hF1);
        strobe_word(8'hF2);
        rx_cmd(8'h3F);
        exp_q.push_back(8'h83);
        exp_q.push_back(8'hF1);
        exp_q.push_back(8'hF2);
        hold_busy = 1'b0;
        cyc(60);
        check("t4_drained", exp_q.size(), 0);

        // 5: soft reset mid-transmit with 3 bytes queued
        exp_q.push_back(8'h31);
        for (int i = 1; i <= 4; i++) strobe_word(8'h30 + 8'(i));
        cyc(2);
        rx_cmd(8'h72);
        check("t5_soft_reset_hi", {31'd0, soft_reset_req}, 32'd1);
        check("t5_drop_count",    {24'd0, drop_count},     32'd0);
        check("t5_streaming",     {31'd0, streaming},      32'd1);
        cyc(1);
        check("t5_soft_reset_lo", {31'd0, soft_reset_req}, 32'd0);
        cyc(40);
        check("t5_drained", exp_q.size(), 0);

        // 6: async reset during WAIT_DONE, then saturate drop_count
        exp_q.push_back(8'h44);
        strobe_word(8'h44);
        cyc(2);
        rx_cmd(8'h73);
        cyc(2);
        check("t6_tx_byte_before",   {24'd0, tx_byte},   32'h44);
        check("t6_streaming_before", {31'd0, streaming}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t6_tx_start",   {31'd0, tx_start},       32'd0);
        check("t6_tx_byte",    {24'd0, tx_byte},        32'd0);
        check("t6_soft_reset", {31'd0, soft_reset_req}, 32'd0);
        check("t6_streaming",  {31'd0, streaming},      32'd1);
        check("t6_drop_count", {24'd0, drop_count},     32'd0);
        cyc(1);
        rst_n = 1'b1;
        hold_busy = 1'b1;
        cyc(2);
        for (int i = 0; i < 300; i++) begin
            word_ready = 1'b1;
            ent_byte   = i[7:0];
            cyc(1);
            if (i == 257) check("t6_drop_count_fe", {24'd0, drop_count}, 32'hFE);
        end
        word_ready = 1'b0;
        cyc(1);
        check("t6_drop_count_ff", {24'd0, drop_count}, 32'hFF);
        for (int i = 0; i < 4; i++) exp_q.push_back(8'(i));
        hold_busy = 1'b0;
        cyc(80);
        check("t6_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
